// File: rtl/fetch_basic_pkg.sv
// Shared types for the fetch front end: address/instruction widths, the
// buffered {inst, pc} entry and the val/rdy handshake helper.
package fetch_basic_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [INST_W-1:0] inst_t;

  typedef struct packed {
    inst_t inst;
    addr_t pc;
  } fetch_entry_t;

  // A val/rdy pair transfers only when both sides agree in the same cycle.
  function automatic logic xfer(input logic val, input logic rdy);
    return val && rdy;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO with push/pop/clear and an occupancy count.
// Head data is presented combinationally; storage is not reset.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  output logic [W-1:0]                 pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= bump(wptr);
      if (do_pop)  rptr <= bump(rptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_basic.sv
// Sequential-PC fetch unit: issues instruction-memory requests, pairs each
// response with its PC and hands {inst, pc} to decode; squash redirects.
module fetch_basic
  import fetch_basic_pkg::*;
#(
  parameter addr_t p_rst_addr      = 32'h200,
  parameter int    p_max_in_flight = 2
) (
  input  logic  clk,
  input  logic  rst,
  output logic  mem_req_val,
  input  logic  mem_req_rdy,
  output addr_t mem_req_addr,
  input  logic  mem_resp_val,
  output logic  mem_resp_rdy,
  input  inst_t mem_resp_data,
  output logic  D_val,
  input  logic  D_rdy,
  output inst_t D_inst,
  output addr_t D_pc,
  input  logic  squash,
  input  addr_t squash_pc
);

  localparam int CW = $clog2(p_max_in_flight + 1);
  localparam int EW = $bits(fetch_entry_t);

  addr_t         pc;
  logic [CW-1:0] in_flight;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] pc_count;
  logic [CW-1:0] buf_count;
  logic [CW:0]   occupancy;
  addr_t         pc_head;
  fetch_entry_t  buf_in;
  fetch_entry_t  buf_head;
  logic          req_fire;
  logic          resp_fire;
  logic          d_fire;
  logic          buf_push;

  // Issue only while every outstanding request is guaranteed a buffer slot.
  assign occupancy    = {1'b0, in_flight} + {1'b0, buf_count};
  assign mem_req_val  = !rst && !squash && (occupancy < (CW+1)'(p_max_in_flight));
  assign mem_req_addr = pc;
  assign mem_resp_rdy = 1'b1;
  assign req_fire     = xfer(mem_req_val, mem_req_rdy);

  // Responses with nothing outstanding belong to requests abandoned by reset.
  assign resp_fire = !rst && xfer(mem_resp_val, mem_resp_rdy) && (pc_count != '0);
  assign buf_push  = resp_fire && (drop_cnt == '0) && !squash;

  assign D_val  = !rst && !squash && (buf_count != '0);
  assign d_fire = xfer(D_val, D_rdy);
  assign D_inst = buf_head.inst;
  assign D_pc   = buf_head.pc;

  assign buf_in.inst = mem_resp_data;
  assign buf_in.pc   = pc_head;

  fetch_fifo #(.W(32), .DEPTH(p_max_in_flight)) u_pc_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (1'b0),
    .push      (req_fire),
    .push_data (pc),
    .pop       (resp_fire),
    .pop_data  (pc_head),
    .count     (pc_count)
  );

  fetch_fifo #(.W(EW), .DEPTH(p_max_in_flight)) u_resp_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (squash),
    .push      (buf_push),
    .push_data (buf_in),
    .pop       (d_fire),
    .pop_data  (buf_head),
    .count     (buf_count)
  );

  // Squash outranks every other update; words still in flight get dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= p_rst_addr;
      in_flight <= '0;
      drop_cnt  <= '0;
    end else begin
      in_flight <= in_flight + CW'(req_fire) - CW'(resp_fire);
      if (squash) begin
        pc       <= squash_pc;
        drop_cnt <= in_flight - CW'(resp_fire);
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (resp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

endmodule
